// File: rtl/ov7670_capture_writer.sv
// ov7670_capture_writer
//   Camera-side writer for the frame buffer. Samples the OV7670 parallel
//   byte stream (VSYNC/HREF/D), pairs bytes into RGB565 pixels, reduces them
//   to RGB444 and issues one write per stored pixel at linear address
//   y*H_ACTIVE+x.
//
//   Optional feature macro: CAPTURE_DECIMATE_EN
//     Defined     : sensor delivers VGA; only even pixels of even lines are
//                   stored. Raw pixel/line counters track the full stream.
//     Not defined : every pixel and line is stored directly (QVGA sensor).
//
//   Handshake: the write side is a plain strobe with no back-pressure.
//   wr_addr/wr_data are meaningful only in a cycle where wr_en=1, and
//   frame_done/frame_err are single-cycle pulses. These pulses never coincide
//   with each other, and each frame produces at most one of them.
//
//   dbg_state_o exposes the FSM state (0 WAIT_FRAME, 1 LINE_IDLE, 2 BYTE_LO,
//   3 BYTE_HI) so checkers can bind to it.
module ov7670_capture_writer #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        dbg_state_o
);

  // Counters are sized for the raw (2x) extent so one width serves both
  // builds. The stored counters saturate at H_ACTIVE/V_ACTIVE.
  localparam int XW = $clog2(2 * H_ACTIVE + 1);
  localparam int YW = $clog2(2 * V_ACTIVE + 1);

  localparam logic [XW-1:0]     H_X = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     V_Y = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_A = ADDR_W'(H_ACTIVE);
`ifdef CAPTURE_DECIMATE_EN
  localparam logic [XW-1:0]     H2_X = XW'(2 * H_ACTIVE);
  localparam logic [YW-1:0]     V2_Y = YW'(2 * V_ACTIVE);
`endif

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LINE_IDLE  = 2'd1,
    BYTE_LO    = 2'd2,
    BYTE_HI    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              vsync_q, href_q;
  // Only the high-byte bits that survive the RGB565->RGB444 reduction are
  // kept: R[4:1] is byte[7:4] and G[5:3] is byte[2:0].
  logic [6:0]        hi_q, hi_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  // Running row base y*H_ACTIVE. This replaces a multiplier in the address path.
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef CAPTURE_DECIMATE_EN
  logic [XW-1:0]     xr_q, xr_d;
  logic [YW-1:0]     yr_q, yr_d;
`endif

  logic vsync_fall, href_fall;
  logic take_pixel, line_end, frame_chk;

  assign vsync_fall = !cam_vsync && vsync_q;
  assign href_fall  = !cam_href  && href_q;

  // FSM next state plus the pixel, line-end and frame-end bookkeeping.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    x_d        = x_q;
    y_d        = y_q;
    base_d     = base_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    take_pixel = 1'b0;
    line_end   = 1'b0;
    frame_chk  = 1'b0;
`ifdef CAPTURE_DECIMATE_EN
    xr_d       = xr_q;
    yr_d       = yr_q;
`endif

    case (state_q)
      WAIT_FRAME: begin
        // Data is ignored until a clean frame start, so a frame already
        // running when reset is released is never stored partially.
        if (vsync_fall) begin
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
`ifdef CAPTURE_DECIMATE_EN
          xr_d    = '0;
          yr_d    = '0;
`endif
          state_d = LINE_IDLE;
        end
      end
      LINE_IDLE: begin
        if (cam_vsync) begin
          // VSYNC together with HREF means the sensor cut a line short.
          if (cam_href) err_d = 1'b1;
          else          frame_chk = 1'b1;
          state_d = WAIT_FRAME;
        end else if (cam_href) begin
          hi_d    = {cam_data[7:4], cam_data[2:0]};
          state_d = BYTE_LO;
        end
      end
      BYTE_LO: begin
        if (cam_vsync && cam_href) begin
          // The half-formed pixel is dropped along with the frame.
          err_d   = 1'b1;
          state_d = WAIT_FRAME;
        end else if (cam_href) begin
          take_pixel = 1'b1;
          state_d    = BYTE_HI;
        end else if (href_fall) begin
          // The line ended after a lone high byte. That byte is discarded.
          line_end = 1'b1;
          state_d  = LINE_IDLE;
        end
      end
      BYTE_HI: begin
        if (cam_vsync && cam_href) begin
          err_d   = 1'b1;
          state_d = WAIT_FRAME;
        end else if (cam_href) begin
          hi_d    = {cam_data[7:4], cam_data[2:0]};
          state_d = BYTE_LO;
        end else if (href_fall) begin
          line_end = 1'b1;
          state_d  = LINE_IDLE;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase

    if (take_pixel) begin
`ifdef CAPTURE_DECIMATE_EN
      if (!xr_q[0] && !yr_q[0]) begin
        if (x_q < H_X && y_q < V_Y) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_W'(x_q);
          wr_data_d = {hi_q[6:3], hi_q[2:0], cam_data[7], cam_data[4:1]};
        end
        if (x_q < H_X) x_d = x_q + XW'(1);
      end
      if (xr_q < H2_X) xr_d = xr_q + XW'(1);
`else
      if (x_q < H_X && y_q < V_Y) begin
        wr_en_d   = 1'b1;
        wr_addr_d = base_q + ADDR_W'(x_q);
        wr_data_d = {hi_q[6:3], hi_q[2:0], cam_data[7], cam_data[4:1]};
      end
      if (x_q < H_X) x_d = x_q + XW'(1);
`endif
    end

    if (line_end) begin
`ifdef CAPTURE_DECIMATE_EN
      // Raw lines always advance. A stored line advances only when it came
      // from an even raw line that actually held a pixel.
      if (xr_q != '0) begin
        if (!yr_q[0] && x_q != '0 && y_q < V_Y) begin
          y_d    = y_q + YW'(1);
          base_d = base_q + H_A;
        end
        if (yr_q < V2_Y) yr_d = yr_q + YW'(1);
      end
      xr_d = '0;
      x_d  = '0;
`else
      // Lines without a complete pixel do not count.
      if (x_q != '0) begin
        if (y_q < V_Y) begin
          y_d    = y_q + YW'(1);
          base_d = base_q + H_A;
        end
      end
      x_d = '0;
`endif
    end

    if (frame_chk) begin
`ifdef CAPTURE_DECIMATE_EN
      if (yr_q == V2_Y) done_d = 1'b1;
      else              err_d  = 1'b1;
`else
      if (y_q == V_Y) done_d = 1'b1;
      else            err_d  = 1'b1;
`endif
    end
  end

  // State register, input edge samplers and the registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= WAIT_FRAME;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      hi_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      base_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CAPTURE_DECIMATE_EN
      xr_q      <= '0;
      yr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      vsync_q   <= cam_vsync;
      href_q    <= cam_href;
      hi_q      <= hi_d;
      x_q       <= x_d;
      y_q       <= y_d;
      base_q    <= base_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CAPTURE_DECIMATE_EN
      xr_q      <= xr_d;
      yr_q      <= yr_d;
`endif
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ov7670_capture_writer.sv
// tb_ov7670_capture_writer
//   Scoreboard bench on a reduced 8x6 geometry. The stimulus tasks push the
//   expected writes and frame events into exp_q. A monitor pops an entry and
//   compares it whenever the DUT strobes wr_en, frame_done or frame_err.
//   Entry layout: {kind[1:0], addr, data}, where kind is 0 for a write,
//   1 for frame_done and 2 for frame_err.
module tb_ov7670_capture_writer;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 6;
  localparam int W  = 2 + AW + 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cam_vsync, cam_href;
  logic [7:0]    cam_data;
  logic          wr_en, frame_done, frame_err;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [1:0]    dbg_state;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  // Pixel table with hand-reduced RGB444 values.
  logic [15:0]   tbl_pix[8];
  logic [11:0]   tbl_exp[8];
  int            pat_off   = 0;
  bit            pat_const = 1'b1;
  bit            in_frame  = 1'b0;
  int            y_exp     = 0;

  ov7670_capture_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .dbg_state_o(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (wr_en || frame_done || frame_err) begin
      logic [W-1:0] act;
      logic [W-1:0] req;
      check("single_event", 32'($countones({wr_en, frame_done, frame_err})), 32'd1);
      if (wr_en) act = {2'b00, wr_addr, wr_data};
      else       act = {frame_err, frame_done, {(AW+12){1'b0}}};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got %h, expected nothing", act);
      end else begin
        req = exp_q.pop_front();
        check("event", 32'(act), 32'(req));
      end
    end
  end

  // Driver tasks. Inputs change on the falling edge.
  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    cam_vsync = v;
    cam_href  = h;
    cam_data  = d;
  endtask

  task automatic send_line(input int npix, input bit half);
    for (int x = 0; x < npix; x++) begin
      int          idx;
      logic [15:0] p;
      logic [11:0] e;
      idx = (x + y_exp + pat_off) % 8;
      p = pat_const ? 16'hF800 : tbl_pix[idx];
      e = pat_const ? 12'hF00  : tbl_exp[idx];
      cyc(1'b0, 1'b1, p[15:8]);
      cyc(1'b0, 1'b1, p[7:0]);
      if (in_frame && x < H && y_exp < V)
        exp_q.push_back({2'b00, AW'(y_exp * H + x), e});
    end
    if (half) cyc(1'b0, 1'b1, 8'h55);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    if (in_frame && npix > 0 && y_exp < V) y_exp++;
  endtask

  task automatic start_frame();
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    in_frame = 1'b1;
    y_exp    = 0;
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame();
    cyc(1'b1, 1'b0, 8'h00);
    if (in_frame) begin
      if (y_exp == V) exp_q.push_back({2'b01, {(AW+12){1'b0}}});
      else            exp_q.push_back({2'b10, {(AW+12){1'b0}}});
    end
    in_frame = 1'b0;
    start_frame();
  endtask

  // VSYNC rises during the low byte of pixel k, which aborts the frame.
  task automatic abort_line(input int k);
    send_part(k);
    cyc(1'b0, 1'b1, 8'hF8);
    cyc(1'b1, 1'b1, 8'h00);
    exp_q.push_back({2'b10, {(AW+12){1'b0}}});
    in_frame = 1'b0;
    start_frame();
  endtask

  // Sends k full pixels of the current line, with no line end.
  task automatic send_part(input int k);
    for (int x = 0; x < k; x++) begin
      cyc(1'b0, 1'b1, 8'hF8);
      cyc(1'b0, 1'b1, 8'h00);
      if (in_frame && y_exp < V)
        exp_q.push_back({2'b00, AW'(y_exp * H + x), 12'hF00});
    end
  endtask

  // Reset is held for 2 cycles mid-line and released while the line continues.
  task automatic reset_line(input int k);
    send_part(k);
    @(negedge clk);
    rst_n = 1'b0; cam_href = 1'b1; cam_data = 8'hF8;
    @(negedge clk);
    cam_data = 8'h00;
    in_frame = 1'b0;
    check("rst_mid_wr_en",   32'(wr_en),      32'd0);
    check("rst_mid_wr_addr", 32'(wr_addr),    32'd0);
    check("rst_mid_wr_data", 32'(wr_data),    32'd0);
    check("rst_mid_done",    32'(frame_done), 32'd0);
    check("rst_mid_err",     32'(frame_err),  32'd0);
    check("rst_mid_state",   32'(dbg_state),  32'd0);
    @(negedge clk);
    rst_n = 1'b1; cam_data = 8'hF8;
    cyc(1'b0, 1'b1, 8'h00);
    send_part(3);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    tbl_pix[0] = 16'hF800; tbl_exp[0] = 12'hF00;
    tbl_pix[1] = 16'h07E0; tbl_exp[1] = 12'h0F0;
    tbl_pix[2] = 16'h001F; tbl_exp[2] = 12'h00F;
    tbl_pix[3] = 16'hFFFF; tbl_exp[3] = 12'hFFF;
    tbl_pix[4] = 16'h1234; tbl_exp[4] = 12'h14A;
    tbl_pix[5] = 16'hA5C3; tbl_exp[5] = 12'hAB1;
    tbl_pix[6] = 16'h8000; tbl_exp[6] = 12'h800;
    tbl_pix[7] = 16'h0040; tbl_exp[7] = 12'h000;

    // Reset.
    rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wr_en",   32'(wr_en),      32'd0);
    check("rst_wr_addr", 32'(wr_addr),    32'd0);
    check("rst_wr_data", 32'(wr_data),    32'd0);
    check("rst_done",    32'(frame_done), 32'd0);
    check("rst_err",     32'(frame_err),  32'd0);
    check("rst_state",   32'(dbg_state),  32'd0);
    rst_n = 1'b1;

    // Data arriving before the first frame start is ignored.
    send_line(4, 1'b0);
    start_frame();

    // Full frame of F800 pixels.
    pat_const = 1'b1;
    for (int l = 0; l < V; l++) send_line(H, 1'b0);
    end_frame();

    // The first line carries 2.5 pixels (07E0, 001F, then a half pixel). A
    // line holding only one byte follows and must not count as a line.
    pat_const = 1'b0; pat_off = 1;
    send_line(2, 1'b1);
    send_line(0, 1'b1);
    for (int l = 0; l < V - 1; l++) send_line(H, 1'b0);
    end_frame();

    // Short frame of 3 lines.
    pat_off = 0;
    for (int l = 0; l < 3; l++) send_line(H, 1'b0);
    end_frame();

    // Oversize frame: 10 pixels per line and 8 lines. The next frame starts at addr 0.
    pat_off = 3;
    for (int l = 0; l < V + 2; l++) send_line(H + 2, 1'b0);
    end_frame();

    // A frame aborted mid-line by VSYNC.
    pat_const = 1'b1;
    send_line(H, 1'b0);
    send_line(H, 1'b0);
    abort_line(3);

    // Reset mid-line. Nothing is written until the next frame start.
    send_line(H, 1'b0);
    reset_line(4);
    send_line(H, 1'b0);
    end_frame();

    // A clean frame after the reset, starting from addr 0.
    pat_const = 1'b0; pat_off = 5;
    for (int l = 0; l < V; l++) send_line(H, 1'b0);
    end_frame();

    repeat (10) cyc(1'b0, 1'b0, 8'h00);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time limit for the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "timeout");
  end
endmodule
